// File: rtl/mul_share_arbiter.sv
// ============================================================================
// Module   : mul_share_arbiter
// Brief    : Round-robin arbiter and two-stage sequencer that time-shares one
//            external combinational signed 16x16 multiplier among NUM_REQ
//            requesters. Optional statistics via MUL_SHARE_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic [15:0]           mul_a,
  output logic [15:0]           mul_b,
  input  logic [31:0]           mul_p,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_p
`ifdef MUL_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  logic            r_s1_valid;
  logic [ID_W-1:0] r_s1_id;
  logic [ID_W-1:0] r_rr_ptr;

  logic            w_adv1;
  logic            w_adv2;
  logic            w_found;
  logic            w_grant;
  logic [ID_W-1:0] w_win;
  logic [ID_W-1:0] w_rr_next;
  logic [15:0]     w_sel_a;
  logic [15:0]     w_sel_b;

  assign w_adv2 = !rsp_valid || rsp_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;

  // Two passes give the wrapped scan: indices at/after the pointer first,
  // then those below it. Loop indices stay constant so selection is static.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (ID_W'(i) >= r_rr_ptr)) begin
        w_found = 1'b1;
        w_win   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (ID_W'(i) < r_rr_ptr)) begin
        w_found = 1'b1;
        w_win   = ID_W'(i);
      end
    end
  end

  // Grant is masked while reset is held so requesters never see an accept.
  assign w_grant = w_found && w_adv1 && rst_n;

  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_sel_a      = req_a[16*i +: 16];
        w_sel_b      = req_b[16*i +: 16];
        req_ready[i] = w_grant;
      end
    end
  end

  assign w_rr_next = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : (w_win + ID_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a      <= '0;
      mul_b      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_p      <= '0;
      r_rr_ptr   <= '0;
    end else begin
      if (w_adv2) begin
        rsp_valid <= r_s1_valid;
        if (r_s1_valid) begin
          rsp_p  <= mul_p;
          rsp_id <= r_s1_id;
        end
      end
      // Operands only move when S1 advances, keeping mul_p stable in a stall.
      if (w_adv1) begin
        r_s1_valid <= w_grant;
        if (w_grant) begin
          mul_a    <= w_sel_a;
          mul_b    <= w_sel_b;
          r_s1_id  <= w_win;
          r_rr_ptr <= w_rr_next;
        end
      end
    end
  end

`ifdef MUL_SHARE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (w_grant && (grant_cnt != 16'hFFFF)) begin
        grant_cnt <= grant_cnt + 16'd1;
      end
      if (rsp_valid && !rsp_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
// ============================================================================
// Module   : tb_mul_share_arbiter
// Brief    : Directed vector table plus hand sequences for mul_share_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_p;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_p;
`ifdef MUL_SHARE_ARB_STATS_EN
  logic [15:0] grant_cnt;
  logic [15:0] stall_cnt;
`endif

  mul_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Stand-in for the external shared multiplier.
  assign mul_p = 32'($signed({{16{mul_a[15]}}, mul_a}) * $signed({{16{mul_b[15]}}, mul_b}));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic [63:0] a;
    logic [63:0] b;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_v;
    logic [1:0]  exp_id;
    logic [31:0] exp_p;
  } vec_t;

  localparam logic [63:0] P_A = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] P_B = {16'd5, 16'd4, 16'd3, 16'd2};
  localparam logic [63:0] S_A = {48'd0, 16'd3};
  localparam logic [63:0] S_B = {48'd0, 16'hFFFB};
  localparam logic [63:0] X_A = {32'd0, 16'h7FFF, 16'h8000};
  localparam logic [63:0] X_B = {32'd0, 16'h8000, 16'h8000};

  vec_t tbl[40];
  int   n_tbl;
  int   n_vec;
  int   n_err;

  function automatic void add(input logic [3:0] rv, input logic [63:0] a, input logic [63:0] b,
                              input logic rdy, input logic [3:0] er, input logic ev,
                              input logic [1:0] eid, input logic [31:0] ep);
    tbl[n_tbl].rv        = rv;
    tbl[n_tbl].a         = a;
    tbl[n_tbl].b         = b;
    tbl[n_tbl].rdy       = rdy;
    tbl[n_tbl].exp_ready = er;
    tbl[n_tbl].exp_v     = ev;
    tbl[n_tbl].exp_id    = eid;
    tbl[n_tbl].exp_p     = ep;
    n_tbl++;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  initial begin
    n_tbl = 0; n_vec = 0; n_err = 0;
    rst_n = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

    // Single request
    add(4'b0000, P_A, P_B, 1, 4'b0000, 0, 0, 0);                    // v0
    add(4'b0001, S_A, S_B, 1, 4'b0001, 0, 0, 0);                    // v1
    add(4'b0000, S_A, S_B, 1, 4'b0000, 0, 0, 0);                    // v2
    add(4'b0000, S_A, S_B, 1, 4'b0000, 1, 0, 32'hFFFF_FFF1);        // v3
    // Wrap pointer to 0, then all four held valid
    add(4'b1000, P_A, P_B, 1, 4'b1000, 0, 0, 0);                    // v4
    add(4'b1111, P_A, P_B, 1, 4'b0001, 0, 0, 0);                    // v5
    add(4'b1111, P_A, P_B, 1, 4'b0010, 1, 3, 20);                   // v6
    add(4'b1111, P_A, P_B, 1, 4'b0100, 1, 0, 2);                    // v7
    add(4'b1111, P_A, P_B, 1, 4'b1000, 1, 1, 6);                    // v8
    add(4'b1111, P_A, P_B, 1, 4'b0001, 1, 2, 12);                   // v9
    // Rotation with pointer at 2 and 1011 pending
    add(4'b0010, P_A, P_B, 1, 4'b0010, 1, 3, 20);                   // v10
    add(4'b1011, P_A, P_B, 1, 4'b1000, 1, 0, 2);                    // v11
    add(4'b1011, P_A, P_B, 1, 4'b0001, 1, 1, 6);                    // v12
    add(4'b1011, P_A, P_B, 1, 4'b0010, 1, 3, 20);                   // v13
    add(4'b0000, P_A, P_B, 1, 4'b0000, 1, 0, 2);                    // v14
    add(4'b0000, P_A, P_B, 1, 4'b0000, 1, 1, 6);                    // v15
    // Three-request stream with five cycles of backpressure
    add(4'b0111, P_A, P_B, 1, 4'b0100, 0, 0, 0);                    // v16
    add(4'b0011, P_A, P_B, 1, 4'b0001, 0, 0, 0);                    // v17
    for (int k = 0; k < 5; k++)
      add(4'b0010, P_A, P_B, 0, 4'b0000, 1, 2, 12);                 // v18..v22
    add(4'b0010, P_A, P_B, 1, 4'b0010, 1, 2, 12);                   // v23
    add(4'b0000, P_A, P_B, 1, 4'b0000, 1, 0, 2);                    // v24
    add(4'b0000, P_A, P_B, 1, 4'b0000, 1, 1, 6);                    // v25
    add(4'b0000, P_A, P_B, 1, 4'b0000, 0, 0, 0);                    // v26
    // S2 stalled but S1 empty still accepts one grant
    add(4'b0001, P_A, P_B, 0, 4'b0001, 0, 0, 0);                    // v27
    add(4'b0000, P_A, P_B, 0, 4'b0000, 0, 0, 0);                    // v28
    add(4'b0010, P_A, P_B, 0, 4'b0010, 1, 0, 2);                    // v29
    add(4'b0100, P_A, P_B, 0, 4'b0000, 1, 0, 2);                    // v30
    add(4'b0100, P_A, P_B, 1, 4'b0100, 1, 0, 2);                    // v31
    add(4'b0000, P_A, P_B, 1, 4'b0000, 1, 1, 6);                    // v32
    add(4'b0000, P_A, P_B, 1, 4'b0000, 1, 2, 12);                   // v33
    // Signed extremes
    add(4'b0001, X_A, X_B, 1, 4'b0001, 0, 0, 0);                    // v34
    add(4'b0010, X_A, X_B, 1, 4'b0010, 0, 0, 0);                    // v35
    add(4'b0000, X_A, X_B, 1, 4'b0000, 1, 0, 32'h4000_0000);        // v36
    add(4'b0000, X_A, X_B, 1, 4'b0000, 1, 1, 32'hC000_8000);        // v37

    // Reset and its state
    #3 rst_n = 1'b0;
    req_valid = 4'b1111; req_a = P_A; req_b = P_B;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset mul_a", 32'(mul_a), 32'd0);
    chk("reset mul_b", 32'(mul_b), 32'd0);
    chk("reset rsp_id", 32'(rsp_id), 32'd0);
    chk("reset rsp_p", rsp_p, 32'd0);
    req_valid = '0;
    rst_n = 1'b1;

    for (int i = 0; i < n_tbl; i++) begin
      @(posedge clk);
      #1;
      req_valid = tbl[i].rv;
      req_a     = tbl[i].a;
      req_b     = tbl[i].b;
      rsp_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) begin
        chk($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(tbl[i].exp_id));
        chk($sformatf("v%0d rsp_p", i), rsp_p, tbl[i].exp_p);
      end
    end

    // Fill S1 and S2 under backpressure, then reset mid-stream
    @(posedge clk); #1;
    req_valid = 4'b1111; req_a = P_A; req_b = P_B; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst full rsp_valid", 32'(rsp_valid), 32'd1);
    chk("midrst full req_ready", 32'(req_ready), 32'd0);
`ifdef MUL_SHARE_ARB_STATS_EN
    chk("grant_cnt total", 32'(grant_cnt), 32'd21);
    chk("stall_cnt total", 32'(stall_cnt), 32'd7);
`endif
    rst_n = 1'b0;
    #1;
    chk("midrst async rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd0);
`ifdef MUL_SHARE_ARB_STATS_EN
    chk("midrst grant_cnt", 32'(grant_cnt), 32'd0);
    chk("midrst stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post-reset grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("post-reset rsp_valid early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("post-reset rsp_valid", 32'(rsp_valid), 32'd1);
    chk("post-reset rsp_id", 32'(rsp_id), 32'd0);
    chk("post-reset rsp_p", rsp_p, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
